pipelined_prefix_adder: RTL and testbench

PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

---
 rtl/pipelined_prefix_adder.sv | 164 ++++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_adder.sv
// Two-stage adder/subtractor with a group-level Brent-Kung carry tree (A+B+c0 or A-B).
// Latency: 2 cycles from acceptance to out_valid. Throughput: 1 beat per cycle.
// Backpressure: stage 2 holds while out_valid && !out_ready; in_ready drops once both stages are full.
// Ports: clk/rst_n (async active-low); in_valid/in_ready with A, B, c0, sub;
//        out_valid/out_ready with S, cout (not-borrow in sub mode), ovf (signed overflow), zero.
module pipelined_prefix_adder #(
  parameter int INPUTSIZE = 32,
  parameter int GROUPSIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INPUTSIZE-1:0] A,
  input  logic [INPUTSIZE-1:0] B,
  input  logic                 c0,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INPUTSIZE-1:0] S,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero
);

  localparam int NG  = INPUTSIZE / GROUPSIZE;
  localparam int LV  = $clog2(NG);
  localparam int MSB = INPUTSIZE - 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_state_t;

  stage_state_t s1_state, s1_next;
  stage_state_t s2_state, s2_next;
  logic         load1, adv1, drain2;

  // Handshake: stage 1 moves forward when stage 2 is empty or emptying this cycle.
  always_comb begin
    drain2   = (s2_state == FULL) && out_ready;
    adv1     = (s1_state == FULL) && ((s2_state == EMPTY) || out_ready);
    in_ready = (s1_state == EMPTY) || adv1;
    load1    = in_valid && in_ready;

    s1_next = s1_state;
    s2_next = s2_state;
    if (load1)       s1_next = FULL;
    else if (adv1)   s1_next = EMPTY;
    if (adv1)        s2_next = FULL;
    else if (drain2) s2_next = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_state <= EMPTY;
      s2_state <= EMPTY;
    end else begin
      s1_state <= s1_next;
      s2_state <= s2_next;
    end
  end

  // ---------------- Stage 1: effective operand and per-group G/P ----------------
  logic [INPUTSIZE-1:0] b_eff;
  logic                 cin_eff;
  logic [NG-1:0]        grp_g, grp_p;

  always_comb begin
    b_eff   = sub ? ~B : B;
    cin_eff = sub ? 1'b1 : c0;
    grp_g   = '0;
    grp_p   = '1;
    for (int g = 0; g < NG; g++) begin
      for (int j = 0; j < GROUPSIZE; j++) begin
        grp_g[g] = (A[g*GROUPSIZE+j] & b_eff[g*GROUPSIZE+j]) |
                   ((A[g*GROUPSIZE+j] ^ b_eff[g*GROUPSIZE+j]) & grp_g[g]);
        grp_p[g] = grp_p[g] & (A[g*GROUPSIZE+j] ^ b_eff[g*GROUPSIZE+j]);
      end
    end
  end

  logic [INPUTSIZE-1:0] s1_a, s1_b;
  logic                 s1_cin;
  logic [NG-1:0]        s1_g, s1_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_cin <= 1'b0;
      s1_g   <= '0;
      s1_p   <= '0;
    end else if (load1) begin
      s1_a   <= A;
      s1_b   <= b_eff;
      s1_cin <= cin_eff;
      s1_g   <= grp_g;
      s1_p   <= grp_p;
    end
  end

  // ---------------- Stage 2: Brent-Kung carries, sum and flags ----------------
  logic [NG-1:0]        pfx_g, pfx_p;
  logic [NG-1:0]        grp_cin;
  logic [INPUTSIZE-1:0] sum;
  logic                 rc;

  // The carry-in is folded into group 0, so each finished prefix G is the
  // carry out of that group. Updates are done in place: within one level the
  // nodes written and the nodes read are disjoint residues mod 2^l.
  always_comb begin
    pfx_g    = s1_g;
    pfx_p    = s1_p;
    pfx_g[0] = s1_g[0] | (s1_p[0] & s1_cin);
    // up-sweep: node i (i+1 a multiple of 2^l) absorbs its left neighbour span
    for (int l = 1; l <= LV; l++) begin
      for (int i = 0; i < NG; i++) begin
        if (((i + 1) % (1 << l)) == 0) begin
          pfx_g[i] = pfx_g[i] | (pfx_p[i] & pfx_g[i - (1 << (l - 1))]);
          pfx_p[i] = pfx_p[i] & pfx_p[i - (1 << (l - 1))];
        end
      end
    end
    // down-sweep: fill the mid-points from the completed prefixes to their left
    for (int l = LV - 1; l >= 1; l--) begin
      for (int i = 0; i < NG; i++) begin
        if ((((i + 1) % (1 << l)) == (1 << (l - 1))) && (i >= (1 << l))) begin
          pfx_g[i] = pfx_g[i] | (pfx_p[i] & pfx_g[i - (1 << (l - 1))]);
        end
      end
    end
  end

  assign grp_cin = {pfx_g[NG-2:0], s1_cin};

  // Bits inside a group ripple from that group's prefix carry-in.
  always_comb begin
    sum = '0;
    rc  = 1'b0;
    for (int g = 0; g < NG; g++) begin
      rc = grp_cin[g];
      for (int j = 0; j < GROUPSIZE; j++) begin
        sum[g*GROUPSIZE+j] = s1_a[g*GROUPSIZE+j] ^ s1_b[g*GROUPSIZE+j] ^ rc;
        rc = (s1_a[g*GROUPSIZE+j] & s1_b[g*GROUPSIZE+j]) |
             ((s1_a[g*GROUPSIZE+j] ^ s1_b[g*GROUPSIZE+j]) & rc);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (adv1) begin
      S    <= sum;
      cout <= pfx_g[NG-1];
      ovf  <= (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
      zero <= (sum == '0);
    end
  end

  assign out_valid = (s2_state == FULL);

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: directed corner cases on a 32/4 instance,
// plus a randomized stream shared by 8/2, 16/4, 32/4 and 64/2 instances.
module tb_pipelined_prefix_adder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, c0, sub;
  logic [63:0] a64, b64;

  logic        in_ready, out_valid, cout, ovf, zero;
  logic [31:0] s;
  logic        rdy8, vld8, co8, ov8, z8;
  logic [7:0]  s8;
  logic        rdy16, vld16, co16, ov16, z16;
  logic [15:0] s16;
  logic        rdy64, vld64, co64, ov64, z64;
  logic [63:0] s64;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        c0;
    logic        sub;
  } beat_t;

  pipelined_prefix_adder #(.INPUTSIZE(32), .GROUPSIZE(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a64[31:0]), .B(b64[31:0]), .c0(c0), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .S(s), .cout(cout), .ovf(ovf), .zero(zero));

  pipelined_prefix_adder #(.INPUTSIZE(8), .GROUPSIZE(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .A(a64[7:0]), .B(b64[7:0]), .c0(c0), .sub(sub),
    .out_valid(vld8), .out_ready(out_ready), .S(s8), .cout(co8), .ovf(ov8), .zero(z8));

  pipelined_prefix_adder #(.INPUTSIZE(16), .GROUPSIZE(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .A(a64[15:0]), .B(b64[15:0]), .c0(c0), .sub(sub),
    .out_valid(vld16), .out_ready(out_ready), .S(s16), .cout(co16), .ovf(ov16), .zero(z16));

  pipelined_prefix_adder #(.INPUTSIZE(64), .GROUPSIZE(2)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .A(a64), .B(b64), .c0(c0), .sub(sub),
    .out_valid(vld64), .out_ready(out_ready), .S(s64), .cout(co64), .ovf(ov64), .zero(z64));

  // Reference: plain unsigned/signed arithmetic on w-bit operands.
  // Returns {zero, ovf, cout, S zero-extended to 64 bits}.
  function automatic logic [66:0] ref_model(input int w, input beat_t bt);
    logic [63:0]        mask, am, bm, sv;
    logic [65:0]        ur;
    logic signed [63:0] ta, tb;
    logic signed [65:0] sa, sb, sr, maxv, minv;
    logic               co, ov;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = bt.a & mask;
    bm   = bt.b & mask;
    if (bt.sub) begin
      ur = {2'b00, am} - {2'b00, bm};
      co = (am >= bm);
    end else begin
      ur = {2'b00, am} + {2'b00, bm} + {65'd0, bt.c0};
      co = ur[w];
    end
    sv   = ur[63:0] & mask;
    ta   = $signed(am << (64 - w)) >>> (64 - w);
    tb   = $signed(bm << (64 - w)) >>> (64 - w);
    sa   = ta;
    sb   = tb;
    sr   = bt.sub ? (sa - sb) : (sa + sb + (bt.c0 ? 66'sd1 : 66'sd0));
    maxv = (66'sd1 <<< (w - 1)) - 66'sd1;
    minv = -(66'sd1 <<< (w - 1));
    ov   = (sr > maxv) || (sr < minv);
    return {(sv == 64'd0), ov, co, sv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat on an idle pipe and wait (bounded) for its result.
  task automatic run_single(input beat_t bt, output int lat, output logic [66:0] got);
    a64 = bt.a; b64 = bt.b; c0 = bt.c0; sub = bt.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    got = {zero, ovf, cout, 32'd0, s};
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({out_valid, s, cout, ovf, zero} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h exp 0", {out_valid, s, cout, ovf, zero});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_cycle in_ready=%b exp 1", in_ready);
    end
  endtask

  task automatic test_add_wrap();
    int lat; logic [66:0] got;
    run_single('{a: 64'hFFFF_FFFF, b: 64'h1, c0: 1'b0, sub: 1'b0}, lat, got);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL add_wrap_latency got %0d exp 2", lat); end
    vectors++;
    if (got[31:0] !== 32'h0) begin miscompares++; $display("FAIL add_wrap_S got %h exp 00000000", got[31:0]); end
    vectors++;
    if (got[66:64] !== 3'b101) begin miscompares++; $display("FAIL add_wrap_flags zero/ovf/cout got %b exp 101", got[66:64]); end
    tick();
  endtask

  task automatic test_sub_ovf();
    int lat; logic [66:0] got;
    run_single('{a: 64'h8000_0000, b: 64'h1, c0: 1'b0, sub: 1'b1}, lat, got);
    vectors++;
    if (got[31:0] !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL sub_ovf_S got %h exp 7fffffff", got[31:0]); end
    vectors++;
    if (got[66:64] !== 3'b011) begin miscompares++; $display("FAIL sub_ovf_flags zero/ovf/cout got %b exp 011", got[66:64]); end
    tick();
  endtask

  task automatic test_add_ovf();
    int lat; logic [66:0] got;
    run_single('{a: 64'h7FFF_FFFF, b: 64'h0, c0: 1'b1, sub: 1'b0}, lat, got);
    vectors++;
    if (got[31:0] !== 32'h8000_0000) begin miscompares++; $display("FAIL add_ovf_S got %h exp 80000000", got[31:0]); end
    vectors++;
    if (got[66:64] !== 3'b010) begin miscompares++; $display("FAIL add_ovf_flags zero/ovf/cout got %b exp 010", got[66:64]); end
    tick();
  endtask

  task automatic test_back_pressure();
    beat_t       beats[5];
    beat_t       exp_q[$];
    int          sent = 0, recv = 0;
    logic        acc, drn;
    logic [66:0] e;
    for (int i = 0; i < 5; i++) begin
      beats[i] = '{a: {32'd0, $urandom()}, b: {32'd0, $urandom()},
                   c0: 1'($urandom_range(0, 1)), sub: (i % 2 == 1)};
    end
    for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
      in_valid  = (sent < 5);
      if (sent < 5) begin
        a64 = beats[sent].a; b64 = beats[sent].b; c0 = beats[sent].c0; sub = beats[sent].sub;
      end
      out_ready = (cyc >= 4);
      #1;
      if (cyc == 2 || cyc == 3) begin
        e = ref_model(32, beats[0]);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL bp_stall_handshake cyc %0d in_ready=%b out_valid=%b exp 0/1", cyc, in_ready, out_valid);
        end
        vectors++;
        if ({zero, ovf, cout, 32'd0, s} !== e) begin
          miscompares++;
          $display("FAIL bp_stall_hold cyc %0d got %h exp %h", cyc, {zero, ovf, cout, 32'd0, s}, e);
        end
      end
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra_beat got S=%h exp no beat", s);
        end else begin
          e = ref_model(32, exp_q.pop_front());
          if ({zero, ovf, cout, 32'd0, s} !== e) begin
            miscompares++;
            $display("FAIL bp_beat %0d got %h exp %h", recv, {zero, ovf, cout, 32'd0, s}, e);
          end
        end
        recv++;
      end
      if (acc) begin
        exp_q.push_back(beats[sent]);
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (recv !== 5) begin miscompares++; $display("FAIL bp_count got %0d exp 5", recv); end
  endtask

  task automatic test_reset_mid_stream();
    int lat; logic [66:0] got; beat_t bt;
    out_ready = 1'b0;
    a64 = 64'h1234; b64 = 64'h5678; c0 = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_full out_valid=%b in_ready=%b exp 1/0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || s !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid_immediate out_valid=%b S=%h exp 0/0", out_valid, s);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_flushed out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    bt = '{a: 64'h0000_0000_DEAD_BEEF, b: 64'h0000_0000_DEAD_BEEF, c0: 1'b0, sub: 1'b1};
    run_single(bt, lat, got);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL rst_mid_latency got %0d exp 2", lat); end
    vectors++;
    if (got !== ref_model(32, bt)) begin
      miscompares++;
      $display("FAIL rst_mid_value got %h exp %h", got, ref_model(32, bt));
    end
    tick();
  endtask

  task automatic test_random();
    beat_t       exp_q[$];
    beat_t       bt, cur;
    int          sent = 0, recv = 0, cyc = 0;
    int          mode;
    logic        acc, drn;
    logic [66:0] e;
    const int    N = 10000;
    while (recv < N && cyc < 60000) begin
      mode = $urandom_range(0, 7);
      bt.a   = {$urandom(), $urandom()};
      bt.b   = {$urandom(), $urandom()};
      if (mode == 0) bt.a = {64{1'b1}};
      if (mode == 1) bt.b = 64'd0;
      if (mode == 2) bt.b = bt.a;
      bt.c0  = 1'($urandom_range(0, 1));
      bt.sub = 1'($urandom_range(0, 1));
      in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a64 = bt.a; b64 = bt.b; c0 = bt.c0; sub = bt.sub;
      #1;
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (acc) begin
        vectors++;
        if ({rdy8, rdy16, rdy64} !== {3{in_ready}}) begin
          miscompares++;
          $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, {rdy8, rdy16, rdy64}, {3{in_ready}});
        end
      end
      if (drn) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rand_extra_beat cyc %0d got S=%h exp no beat", cyc, s);
        end else begin
          cur = exp_q.pop_front();
          vectors++;
          if ({vld8, vld16, vld64} !== 3'b111) begin
            miscompares++;
            $display("FAIL rand_valid beat %0d got %b exp 111", recv, {vld8, vld16, vld64});
          end
          e = ref_model(32, cur);
          vectors++;
          if ({zero, ovf, cout, 32'd0, s} !== e) begin
            miscompares++;
            $display("FAIL rand_w32 beat %0d got %h exp %h", recv, {zero, ovf, cout, 32'd0, s}, e);
          end
          e = ref_model(8, cur);
          vectors++;
          if ({z8, ov8, co8, 56'd0, s8} !== e) begin
            miscompares++;
            $display("FAIL rand_w8 beat %0d got %h exp %h", recv, {z8, ov8, co8, 56'd0, s8}, e);
          end
          e = ref_model(16, cur);
          vectors++;
          if ({z16, ov16, co16, 48'd0, s16} !== e) begin
            miscompares++;
            $display("FAIL rand_w16 beat %0d got %h exp %h", recv, {z16, ov16, co16, 48'd0, s16}, e);
          end
          e = ref_model(64, cur);
          vectors++;
          if ({z64, ov64, co64, s64} !== e) begin
            miscompares++;
            $display("FAIL rand_w64 beat %0d got %h exp %h", recv, {z64, ov64, co64, s64}, e);
          end
        end
        recv++;
      end
      if (acc) begin
        exp_q.push_back(bt);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (recv !== N || sent !== N) begin
      miscompares++;
      $display("FAIL rand_count sent %0d recv %0d exp %0d", sent, recv, N);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    c0 = 1'b0; sub = 1'b0; a64 = '0; b64 = '0;
    vectors = 0; miscompares = 0;
    test_reset();
    test_add_wrap();
    test_sub_ovf();
    test_add_ovf();
    test_back_pressure();
    test_reset_mid_stream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
